// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and parity helper for the PS/2 receive path.
package ps2_pkg;
   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;
   localparam logic [7:0] CODE_AA = 8'hAA;
   localparam logic [7:0] CODE_00 = 8'h00;
   localparam logic [7:0] CODE_FF = 8'hFF;

   localparam int FRAME_BITS = 11;
   localparam int ENTRY_W    = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } rx_state_e;

   // Odd parity over d7..d0 plus the parity bit.
   function automatic logic parity_ok(input logic [FRAME_BITS-1:0] f);
      return ^f[9:1];
   endfunction
endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO for decoded entries; simultaneous push/pop is legal when full.
module ps2_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      full    = (cnt_q == (AW+1)'(DEPTH));
      empty   = (cnt_q == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      rdata   = empty ? '0 : mem_q[rd_q];
      count   = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end
endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: sync+filter, 11-bit deframing, prefix folding, entry FIFO.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_decoder import ps2_pkg::*; #(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    out_code,
   output logic                          out_release,
   output logic                          out_extended,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          bat_ok,
   output logic                          kbd_overrun,
   output logic                          err_framing,
   output logic                          err_parity,
   output logic                          err_timeout,
   output logic                          overflow
);
   localparam int FW = $clog2(FILTER_LEN);

   // Index 0 is ps2_clk, index 1 is ps2_data.
   logic [1:0]         s1_q, s1_d, s2_q, s2_d, filt_q, filt_d;
   logic [1:0][FW-1:0] fcnt_q, fcnt_d;
   logic               fall;

   always_comb begin
      s1_d   = {ps2_data, ps2_clk};
      s2_d   = s1_q;
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == filt_q[i]) begin
            fcnt_d[i] = '0;
         end else if (fcnt_q[i] == FW'(FILTER_LEN-1)) begin
            filt_d[i] = s2_q[i];
            fcnt_d[i] = '0;
         end else begin
            fcnt_d[i] = fcnt_q[i] + FW'(1);
         end
      end
      fall = filt_q[0] && !filt_d[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 2'b11;
         s2_q   <= 2'b11;
         filt_q <= 2'b11;
         fcnt_q <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   rx_state_e             state_q;
   logic [3:0]            bitcnt_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic                  ext_pend_q, rel_pend_q;
`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);
   logic [TW-1:0]         tmo_q;
`endif

   logic [7:0]            code;
   logic                  frm_bad, par_bad, is_prefix, is_bat, is_ovr, push, pop, full, empty;
   logic [ENTRY_W-1:0]    head;

   always_comb begin
      code      = frame_q[8:1];
      frm_bad   = frame_q[0] || !frame_q[10];
      par_bad   = !parity_ok(frame_q);
      is_prefix = (code == CODE_E0) || (code == CODE_F0);
      is_bat    = (code == CODE_AA) && !ext_pend_q && !rel_pend_q;
      is_ovr    = (code == CODE_00) || (code == CODE_FF);
      push      = (state_q == ST_CHECK) && !frm_bad && !par_bad && !is_prefix && !is_bat && !is_ovr;
      pop       = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bitcnt_q    <= '0;
         frame_q     <= '0;
         ext_pend_q  <= 1'b0;
         rel_pend_q  <= 1'b0;
         bat_ok      <= 1'b0;
         kbd_overrun <= 1'b0;
         err_framing <= 1'b0;
         err_parity  <= 1'b0;
         err_timeout <= 1'b0;
         overflow    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         bat_ok      <= 1'b0;
         kbd_overrun <= 1'b0;
         err_framing <= 1'b0;
         err_parity  <= 1'b0;
         err_timeout <= 1'b0;
         overflow    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall && !filt_q[1]) begin
                  state_q  <= ST_SHIFT;
                  frame_q  <= '0;
                  bitcnt_q <= 4'd1;
`ifdef PS2_RX_TIMEOUT_EN
                  tmo_q    <= '0;
`endif
               end
            end
            ST_SHIFT: begin
               if (fall) begin
                  frame_q[bitcnt_q] <= filt_q[1];
                  bitcnt_q          <= bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'(FRAME_BITS-1)) state_q <= ST_CHECK;
`ifdef PS2_RX_TIMEOUT_EN
                  tmo_q <= '0;
               end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
                  state_q     <= ST_IDLE;
                  err_timeout <= 1'b1;
                  ext_pend_q  <= 1'b0;
                  rel_pend_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
`endif
               end
            end
            ST_CHECK: begin
               state_q <= ST_IDLE;
               if (frm_bad || par_bad) begin
                  err_framing <= frm_bad;
                  err_parity  <= !frm_bad;
                  ext_pend_q  <= 1'b0;
                  rel_pend_q  <= 1'b0;
               end else if (code == CODE_E0) begin
                  ext_pend_q <= 1'b1;
               end else if (code == CODE_F0) begin
                  rel_pend_q <= 1'b1;
               end else if (is_bat) begin
                  bat_ok <= 1'b1;
               end else begin
                  // Both overrun markers and queued codes end the prefix sequence.
                  kbd_overrun <= is_ovr;
                  overflow    <= !is_ovr && full && !pop;
                  ext_pend_q  <= 1'b0;
                  rel_pend_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({ext_pend_q, rel_pend_q, code}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign out_valid    = !empty;
   assign out_code     = head[7:0];
   assign out_release  = head[8];
   assign out_extended = head[9];
endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: bit-banged PS/2 frames, entry scoreboard, pulse counters.
module tb_ps2_rx_decoder;
   localparam int FILTER_LEN     = 8;
   localparam int FIFO_DEPTH     = 8;
   localparam int TIMEOUT_CYCLES = 2000;
   localparam int HALF           = 20;

   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, out_ready = 1'b0;
   logic [7:0] out_code;
   logic       out_release, out_extended, out_valid;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic       bat_ok, kbd_overrun, err_framing, err_parity, err_timeout, overflow;

   ps2_rx_decoder #(.FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .out_code(out_code), .out_release(out_release), .out_extended(out_extended),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
      .bat_ok(bat_ok), .kbd_overrun(kbd_overrun), .err_framing(err_framing),
      .err_parity(err_parity), .err_timeout(err_timeout), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, stop_cyc = 0, rise_cyc = -1, lat = 11, max_cnt = 0, np = 0;
   int n_bat = 0, n_ovr = 0, n_fram = 0, n_par = 0, n_tmo = 0, n_ovf = 0;
   int s_bat = 0, s_ovr = 0, s_fram = 0, s_par = 0, s_tmo = 0, s_ovf = 0;
   logic prev_valid = 1'b0;
   logic [9:0] sb[$];
   logic [9:0] exp_e;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         n_bat  += int'(bat_ok);
         n_ovr  += int'(kbd_overrun);
         n_fram += int'(err_framing);
         n_par  += int'(err_parity);
         n_tmo  += int'(err_timeout);
         n_ovf  += int'(overflow);
         np = $countones({bat_ok, kbd_overrun, err_framing, err_parity, err_timeout, overflow});
         if (np != 0) chk("pulse_onehot", np, 1);
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
         prev_valid = out_valid;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_entry", int'({out_extended, out_release, out_code}), -1);
            else begin
               exp_e = sb.pop_front();
               chk("sb_entry", int'({out_extended, out_release, out_code}), int'(exp_e));
            end
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_pulses(input string tag, input int b, input int o, input int f,
                             input int p, input int t, input int v);
      chk({tag, "_bat"},  n_bat  - s_bat,  b);
      chk({tag, "_ovr"},  n_ovr  - s_ovr,  o);
      chk({tag, "_fram"}, n_fram - s_fram, f);
      chk({tag, "_par"},  n_par  - s_par,  p);
      chk({tag, "_tmo"},  n_tmo  - s_tmo,  t);
      chk({tag, "_ovf"},  n_ovf  - s_ovf,  v);
      s_bat = n_bat; s_ovr = n_ovr; s_fram = n_fram; s_par = n_par; s_tmo = n_tmo; s_ovf = n_ovf;
   endtask

   // Drives nbits of an 11-bit frame; optionally pulses out_ready on the push cycle.
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit pop_at_push);
      logic [10:0] f;
      f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      wait_neg(1);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_neg(HALF);
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         if (i == 10 && pop_at_push) begin
            wait_neg(lat - 1);
            out_ready = 1'b1;
            wait_neg(1);
            out_ready = 1'b0;
            wait_neg(HALF - lat);
         end else begin
            wait_neg(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_neg(3 * HALF);
   endtask

   task automatic send(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b0, 11, 1'b0);
   endtask

   initial begin
      wait_neg(5);
      rst = 1'b0;
      wait_neg(1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_code", int'(out_code), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_flags", int'({out_release, out_extended, bat_ok, kbd_overrun, err_framing,
                             err_parity, err_timeout, overflow}), 0);

      // 1) plain make code
      out_ready = 1'b1;
      rise_cyc  = -1;
      sb.push_back({2'b00, 8'h1C});
      send(8'h1C);
      chk("t1_valid_seen", int'(rise_cyc >= 0), 1);
      if (rise_cyc >= 0) lat = rise_cyc - stop_cyc;
      chk("t1_latency_bound", int'(lat > 1 && lat < HALF), 1);
      chk("t1_count", int'(fifo_count), 0);
      chk("t1_sb_empty", sb.size(), 0);
      chk_pulses("t1", 0, 0, 0, 0, 0, 0);

      // 2) extended release folds into one entry
      max_cnt = 0;
      sb.push_back({2'b11, 8'h75});
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("t2_max_count", max_cnt, 1);
      chk("t2_sb_empty", sb.size(), 0);
      chk_pulses("t2", 0, 0, 0, 0, 0, 0);

      // 3) parity error, then framing error clearing a pending E0
      send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
      chk("t3_par_count", int'(fifo_count), 0);
      chk_pulses("t3p", 0, 0, 0, 1, 0, 0);
      send(8'hE0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      sb.push_back({2'b00, 8'h1C});
      send(8'h1C);
      chk("t3_sb_empty", sb.size(), 0);
      chk_pulses("t3f", 0, 0, 1, 0, 0, 0);

      // 4) BAT, released AA, overrun markers
      send(8'hAA);
      chk("t4_bat_count", int'(fifo_count), 0);
      chk_pulses("t4a", 1, 0, 0, 0, 0, 0);
      sb.push_back({2'b01, 8'hAA});
      send(8'hF0); send(8'hAA);
      send(8'h00);
      send(8'hE0); send(8'hFF);
      sb.push_back({2'b00, 8'h1C});
      send(8'h1C);
      chk("t4_sb_empty", sb.size(), 0);
      chk_pulses("t4b", 0, 2, 0, 0, 0, 0);

      // 5) fill past depth, then push+pop while full
      out_ready = 1'b0;
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         if (i < FIFO_DEPTH) sb.push_back({2'b00, 8'(8'h10 + i)});
         send(8'(8'h10 + i));
      end
      chk("t5_full_count", int'(fifo_count), FIFO_DEPTH);
      chk_pulses("t5a", 0, 0, 0, 0, 0, 1);
      chk("t5_head_a", int'({out_extended, out_release, out_code}), 'h010);
      wait_neg(7);
      chk("t5_head_b", int'({out_extended, out_release, out_code}), 'h010);
      sb.push_back({2'b00, 8'h20});
      send_frame(8'h20, 1'b0, 1'b0, 11, 1'b1);
      chk("t5_full_pushpop_count", int'(fifo_count), FIFO_DEPTH);
      chk_pulses("t5b", 0, 0, 0, 0, 0, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 50 && out_valid; i++) wait_neg(1);
      chk("t5_drained", int'(fifo_count), 0);
      chk("t5_sb_empty", sb.size(), 0);

      // glitch on ps2_clk while data low must not start a frame
      ps2_data = 1'b0;
      wait_neg(3);
      #2 ps2_clk = 1'b0;
      #5 ps2_clk = 1'b1;
      wait_neg(HALF);
      ps2_data = 1'b1;
      wait_neg(HALF);
      sb.push_back({2'b00, 8'h1C});
      send(8'h1C);
      chk("glitch_sb_empty", sb.size(), 0);
      chk_pulses("glitch", 0, 0, 0, 0, 0, 0);

      // reset mid-frame discards the partial frame silently
      send_frame(8'h33, 1'b0, 1'b0, 5, 1'b0);
      rst = 1'b1;
      wait_neg(3);
      rst = 1'b0;
      wait_neg(2);
      sb.push_back({2'b00, 8'h5A});
      send(8'h5A);
      chk("rstmid_sb_empty", sb.size(), 0);
      chk_pulses("rstmid", 0, 0, 0, 0, 0, 0);

`ifdef PS2_RX_TIMEOUT_EN
      // 6) watchdog aborts a stalled frame
      send_frame(8'h1C, 1'b0, 1'b0, 5, 1'b0);
      wait_neg(TIMEOUT_CYCLES + 50);
      chk_pulses("t6a", 0, 0, 0, 0, 1, 0);
      sb.push_back({2'b00, 8'h1C});
      send(8'h1C);
      chk("t6_sb_empty", sb.size(), 0);
      chk_pulses("t6b", 0, 0, 0, 0, 0, 0);
`endif

      wait_neg(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
